// File: rtl/text_word_counter.sv
// -----------------------------------------------------------------------------
// text_word_counter
//
// Streaming keyword counter for SD-card text dumps. One byte per clock is
// taken from the SD/SRAM read path. The block hunts for START_TAG, then counts
// whole-word hits of up to NUM_WORDS programmable words until END_TAG is seen.
// A word is a run of bytes with a delimiter (space, LF, CR, TAB) on both sides.
// The first character of a word compares case-insensitively.
//
// Build option:
//   CASE_FOLD_EN  when defined, every compared character is folded A-Z -> a-z.
//                 The tags are always matched exactly.
//
// Ports:
//   clk              system clock
//   reset_n          synchronous, active-low reset
//   i_clear          synchronous restart that keeps the word configuration;
//                    takes priority over a byte in the same cycle
//   i_byte_valid     i_byte_data holds a byte; it is always consumed
//   i_byte_data      stream byte
//   i_cfg_we         word-slot write strobe (only acted on in HUNT or DONE)
//   i_cfg_idx        slot index; values >= NUM_WORDS are ignored
//   i_cfg_word       word bytes; the first char sits in the top byte of the used length
//   i_cfg_len        word length; 0 disables the slot, > MAX_LEN is clamped
//   o_state          0 = HUNT, 1 = COUNT, 2 = DONE
//   o_tag_found      start tag seen
//   o_end_found      end tag seen
//   o_done           one-cycle pulse on COUNT -> DONE
//   o_counts         slot i count at [i*CNT_W +: CNT_W], saturating
//   o_bytes_scanned  bytes accepted in HUNT and COUNT, saturating
// -----------------------------------------------------------------------------
module text_word_counter #(
   parameter int          NUM_WORDS = 4,
   parameter int          MAX_LEN   = 8,
   parameter int          CNT_W     = 8,
   parameter logic [63:0] START_TAG = "DLAB_TAG",
   parameter logic [63:0] END_TAG   = "DLAB_END"
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_clear,
   input  logic                       i_byte_valid,
   input  logic [7:0]                 i_byte_data,
   input  logic                       i_cfg_we,
   input  logic [2:0]                 i_cfg_idx,
   input  logic [8*MAX_LEN-1:0]       i_cfg_word,
   input  logic [3:0]                 i_cfg_len,
   output logic [1:0]                 o_state,
   output logic                       o_tag_found,
   output logic                       o_end_found,
   output logic                       o_done,
   output logic [NUM_WORDS*CNT_W-1:0] o_counts,
   output logic [31:0]                o_bytes_scanned
);

   // The match window is MAX_LEN word bytes plus a delimiter on each side.
   localparam int WIN    = MAX_LEN + 2;
   localparam int WORD_W = 8 * MAX_LEN;

`ifdef CASE_FOLD_EN
   localparam bit FOLD_ALL = 1'b1;
`else
   localparam bit FOLD_ALL = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t            r_state;
   logic              r_tag_found;
   logic              r_end_found;
   logic              r_done;
   // Only the 7 previous bytes are stored; the incoming byte completes the tag.
   logic [55:0]       r_tag;
   // Previous MAX_LEN+1 bytes; the incoming byte is window position 0.
   logic [7:0]        r_win [WIN-1];
   logic [CNT_W-1:0]  r_cnt [NUM_WORDS];
   logic [31:0]       r_bytes;
   logic [WORD_W-1:0] r_word [NUM_WORDS];
   logic [3:0]        r_len [NUM_WORDS];

   // ---------------------------------------------------------------------------
   // Combinational next values
   // ---------------------------------------------------------------------------
   logic [63:0]          w_tag_next;
   logic [7:0]           w_win_next [WIN];
   logic [NUM_WORDS-1:0] w_match;
   logic [3:0]           w_cfg_len;
   logic                 w_cfg_wr;

   function automatic logic is_delim(input logic [7:0] c);
      return (c == 8'h20) || (c == 8'h0A) || (c == 8'h0D) || (c == 8'h09);
   endfunction

   function automatic logic [7:0] fold(input logic [7:0] c);
      return ((c >= 8'h41) && (c <= 8'h5A)) ? (c | 8'h20) : c;
   endfunction

   function automatic logic char_eq(input logic [7:0] a, input logic [7:0] b,
                                    input logic first);
      return (first || FOLD_ALL) ? (fold(a) == fold(b)) : (a == b);
   endfunction

   // Window and tag as they look once the incoming byte is included, so a
   // word or tag closed by this byte is recognised in the same cycle.
   always_comb begin
      // NOTE: every output of a combinational block is given a value on every
      // path (here unconditionally) so no latch can be inferred.
      w_tag_next    = {r_tag, i_byte_data};
      w_win_next[0] = i_byte_data;
      for (int k = 1; k < WIN; k++) begin
         w_win_next[k] = r_win[k-1];
      end
   end

   // Slot i of length L hits when w[0] and w[L+1] are delimiters and
   // w[L:1] spells the word, w[L] being its first character.
   always_comb begin
      logic       ok;
      logic [7:0] lead;
      w_match = '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         lead = 8'h00;
         for (int k = 2; k < WIN; k++) begin
            if (k == int'(r_len[i]) + 1) lead = w_win_next[k];
         end
         ok = (r_len[i] != 4'd0) && is_delim(w_win_next[0]) && is_delim(lead);
         for (int j = 0; j < MAX_LEN; j++) begin
            if (j < int'(r_len[i])) begin
               ok = ok && char_eq(w_win_next[j+1], r_word[i][8*j +: 8],
                                  j == int'(r_len[i]) - 1);
            end
         end
         w_match[i] = ok;
      end
   end

   assign w_cfg_len = (i_cfg_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : i_cfg_len;
   assign w_cfg_wr  = i_cfg_we && (r_state != ST_COUNT) &&
                      (int'(i_cfg_idx) < NUM_WORDS);

   // ---------------------------------------------------------------------------
   // Word configuration: survives i_clear, only reset_n restores the default.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         // NOTE: the slot arrays are reset on purpose so slot 0 wakes up as
         // "the"; storage arrays are otherwise best left without reset.
         for (int i = 0; i < NUM_WORDS; i++) begin
            r_word[i] <= '0;
            r_len[i]  <= 4'd0;
         end
         r_word[0] <= WORD_W'(24'h746865);
         r_len[0]  <= 4'd3;
      end else if (w_cfg_wr) begin
         r_word[i_cfg_idx] <= i_cfg_word;
         r_len[i_cfg_idx]  <= w_cfg_len;
      end
   end

   // ---------------------------------------------------------------------------
   // Scanner FSM with its registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n || i_clear) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         r_state     <= ST_HUNT;
         r_tag_found <= 1'b0;
         r_end_found <= 1'b0;
         r_done      <= 1'b0;
         r_tag       <= '0;
         r_bytes     <= '0;
         for (int k = 0; k < WIN-1; k++) r_win[k] <= 8'h00;
         for (int i = 0; i < NUM_WORDS; i++) r_cnt[i] <= '0;
      end else begin
         r_done <= 1'b0;
         if (i_byte_valid && (r_state != ST_DONE)) begin
            if (r_bytes != '1) r_bytes <= r_bytes + 32'd1;
            case (r_state)
               ST_HUNT: begin
                  if (w_tag_next == START_TAG) begin
                     r_state     <= ST_COUNT;
                     r_tag_found <= 1'b1;
                     r_tag       <= '0;
                     for (int k = 0; k < WIN-1; k++) r_win[k] <= 8'h00;
                  end else begin
                     r_tag <= w_tag_next[55:0];
                  end
               end
               ST_COUNT: begin
                  // The end tag ends in a letter, so the closing byte never
                  // completes a word and counting can simply stop here.
                  if (w_tag_next == END_TAG) begin
                     r_state     <= ST_DONE;
                     r_end_found <= 1'b1;
                     r_done      <= 1'b1;
                  end else begin
                     r_tag <= w_tag_next[55:0];
                     for (int k = 0; k < WIN-1; k++) r_win[k] <= w_win_next[k];
                     for (int i = 0; i < NUM_WORDS; i++) begin
                        if (w_match[i] && (r_cnt[i] != '1)) begin
                           r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_state         = r_state;
   assign o_tag_found     = r_tag_found;
   assign o_end_found     = r_end_found;
   assign o_done          = r_done;
   assign o_bytes_scanned = r_bytes;

   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_counts
      assign o_counts[g*CNT_W +: CNT_W] = r_cnt[g];
   end

endmodule

// File: tb/tb_text_word_counter.sv
// -----------------------------------------------------------------------------
// tb_text_word_counter
//
// Self-checking bench for text_word_counter. A token-level reference model
// (last-8-bytes tag detection, delimiter-separated tokens compared against the
// configured words) predicts every output after every clock. Directed
// sequences cover the documented scenarios, then randomized rounds mix words,
// delimiters, tags, configuration writes, gaps and clears.
// -----------------------------------------------------------------------------
module tb_text_word_counter;

   localparam int          NUM_WORDS = 4;
   localparam int          MAX_LEN   = 8;
   localparam int          CNT_W     = 8;
   localparam logic [63:0] START_TAG = "DLAB_TAG";
   localparam logic [63:0] END_TAG   = "DLAB_END";
   localparam int          CNT_MAX   = (1 << CNT_W) - 1;

`ifdef CASE_FOLD_EN
   localparam bit FOLD_ALL = 1'b1;
`else
   localparam bit FOLD_ALL = 1'b0;
`endif

   logic                       clk = 1'b0;
   logic                       reset_n;
   logic                       clear;
   logic                       byte_valid;
   logic [7:0]                 byte_data;
   logic                       cfg_we;
   logic [2:0]                 cfg_idx;
   logic [8*MAX_LEN-1:0]       cfg_word;
   logic [3:0]                 cfg_len;
   logic [1:0]                 o_state;
   logic                       o_tag_found;
   logic                       o_end_found;
   logic                       o_done;
   logic [NUM_WORDS*CNT_W-1:0] o_counts;
   logic [31:0]                o_bytes_scanned;

   always #5 clk = ~clk;

   text_word_counter #(
      .NUM_WORDS(NUM_WORDS), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W),
      .START_TAG(START_TAG), .END_TAG(END_TAG)
   ) dut (
      .clk(clk), .reset_n(reset_n), .i_clear(clear),
      .i_byte_valid(byte_valid), .i_byte_data(byte_data),
      .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_word(cfg_word), .i_cfg_len(cfg_len),
      .o_state(o_state), .o_tag_found(o_tag_found), .o_end_found(o_end_found),
      .o_done(o_done), .o_counts(o_counts), .o_bytes_scanned(o_bytes_scanned)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_done_pulses = 0;
   int n_both = 0;
   logic [CNT_W-1:0] p_c0, p_c1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   int          m_state;
   bit          m_tag_found, m_end_found, m_done;
   int          m_cnt [NUM_WORDS];
   int unsigned m_bytes;
   int          m_wlen [NUM_WORDS];
   logic [7:0]  m_wchar [NUM_WORDS][MAX_LEN];
   logic [7:0]  m_hist[$];
   logic [7:0]  m_tok[$];
   bit          m_prev_delim;

   function automatic bit m_is_delim(input logic [7:0] c);
      return (c == 8'h20) || (c == 8'h0A) || (c == 8'h0D) || (c == 8'h09);
   endfunction

   function automatic logic [7:0] m_lower(input logic [7:0] c);
      if (c >= "A" && c <= "Z") return c + 8'd32;
      return c;
   endfunction

   function automatic bit hist_is(input logic [63:0] tag);
      if (m_hist.size() != 8) return 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (m_hist[k] != tag[63-8*k -: 8]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic bit tok_matches(input int s);
      logic [7:0] a, b;
      if (m_wlen[s] == 0 || m_tok.size() != m_wlen[s]) return 1'b0;
      for (int k = 0; k < m_wlen[s]; k++) begin
         a = m_tok[k];
         b = m_wchar[s][k];
         if (k == 0 || FOLD_ALL) begin
            if (m_lower(a) != m_lower(b)) return 1'b0;
         end else if (a != b) begin
            return 1'b0;
         end
      end
      return 1'b1;
   endfunction

   task automatic model_reset_stream();
      m_state = 0; m_tag_found = 0; m_end_found = 0; m_done = 0;
      m_bytes = 0; m_prev_delim = 0;
      for (int s = 0; s < NUM_WORDS; s++) m_cnt[s] = 0;
      m_hist.delete();
      m_tok.delete();
   endtask

   task automatic model_reset_cfg();
      for (int s = 0; s < NUM_WORDS; s++) m_wlen[s] = 0;
      m_wlen[0] = 3;
      m_wchar[0][0] = "t"; m_wchar[0][1] = "h"; m_wchar[0][2] = "e";
   endtask

   task automatic model_step();
      int L;
      m_done = 0;
      if (!reset_n) begin
         model_reset_stream();
         model_reset_cfg();
         return;
      end
      if (cfg_we && m_state != 1 && cfg_idx < NUM_WORDS) begin
         L = (cfg_len > MAX_LEN) ? MAX_LEN : int'(cfg_len);
         m_wlen[cfg_idx] = L;
         for (int k = 0; k < L; k++) m_wchar[cfg_idx][k] = cfg_word[8*(L-1-k) +: 8];
      end
      if (clear) begin
         model_reset_stream();
      end else if (byte_valid && m_state != 2) begin
         if (m_bytes != 32'hFFFF_FFFF) m_bytes++;
         m_hist.push_back(byte_data);
         if (m_hist.size() > 8) void'(m_hist.pop_front());
         if (m_state == 0) begin
            if (hist_is(START_TAG)) begin
               m_state = 1; m_tag_found = 1; m_prev_delim = 0;
               m_hist.delete();
               m_tok.delete();
            end
         end else if (hist_is(END_TAG)) begin
            m_state = 2; m_end_found = 1; m_done = 1;
         end else if (m_is_delim(byte_data)) begin
            if (m_prev_delim) begin
               for (int s = 0; s < NUM_WORDS; s++)
                  if (tok_matches(s) && m_cnt[s] < CNT_MAX) m_cnt[s]++;
            end
            m_tok.delete();
            m_prev_delim = 1;
         end else begin
            m_tok.push_back(byte_data);
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus helpers: every clock goes through tick(), which checks all outputs
   // ---------------------------------------------------------------------------
   task automatic tick();
      logic [CNT_W-1:0] c0, c1;
      model_step();
      @(posedge clk);
      #1;
      if (o_done) n_done_pulses++;
      c0 = o_counts[0 +: CNT_W];
      c1 = o_counts[CNT_W +: CNT_W];
      if (c0 != p_c0 && c1 != p_c1) n_both++;
      p_c0 = c0;
      p_c1 = c1;
      check("state",     o_state,         m_state);
      check("tag_found", o_tag_found,     m_tag_found);
      check("end_found", o_end_found,     m_end_found);
      check("done",      o_done,          m_done);
      check("bytes",     o_bytes_scanned, m_bytes);
      for (int s = 0; s < NUM_WORDS; s++)
         check($sformatf("count%0d", s), o_counts[s*CNT_W +: CNT_W], m_cnt[s]);
   endtask

   task automatic send_str(input string s, input int max_gap);
      int gap;
      for (int k = 0; k < s.len(); k++) begin
         gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
         byte_valid = 1'b0;
         repeat (gap) tick();
         byte_valid = 1'b1;
         byte_data  = s[k];
         tick();
      end
      byte_valid = 1'b0;
   endtask

   task automatic cfg_write(input int idx, input string w, input int len);
      logic [8*MAX_LEN-1:0] v;
      int L;
      L = (len > MAX_LEN) ? MAX_LEN : len;
      v = {$urandom, $urandom};   // junk beyond the used length must not matter
      for (int k = 0; k < L; k++) v[8*(L-1-k) +: 8] = (k < w.len()) ? w[k] : 8'h3F;
      cfg_word = v;
      cfg_idx  = idx[2:0];
      cfg_len  = len[3:0];
      cfg_we   = 1'b1;
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Randomized rounds
   // ---------------------------------------------------------------------------
   string tok_pool [15] = '{"the", "The", "THE", "tHe", "a", "A", "cat", "Cat",
                            "cAT", "he", "dog", "xx", "elephant", "Elephant", "elephants"};
   string word_pool [8] = '{"the", "The", "a", "cat", "he", "dog", "elephant", "HE"};
   string delim_pool [4] = '{" ", "\n", "\t", "\015"};

   task automatic random_cfg();
      string w;
      int    len;
      w = word_pool[$urandom_range(7, 0)];
      case ($urandom_range(5, 0))
         0:       len = 0;
         1:       len = 15;
         2:       len = $urandom_range(w.len(), 1);
         default: len = w.len();
      endcase
      cfg_write($urandom_range(7, 0), w, len);
   endtask

   task automatic random_piece(input int max_gap);
      int p;
      p = $urandom_range(99, 0);
      if (p < 3) begin
         send_str("DLAB_END", max_gap);
      end else if (p < 5) begin
         send_str("DLAB_TAG", max_gap);
      end else if (p < 8) begin
         random_cfg();
      end else if (p < 9) begin
         clear      = 1'b1;
         byte_valid = $urandom_range(1, 0) == 1;
         byte_data  = 8'h20;
         tick();
         clear      = 1'b0;
         byte_valid = 1'b0;
      end else begin
         send_str(tok_pool[$urandom_range(14, 0)], max_gap);
      end
      if ($urandom_range(3, 0) != 0) send_str(delim_pool[$urandom_range(3, 0)], max_gap);
   endtask

   task automatic random_rounds();
      int gap;
      for (int r = 0; r < 20; r++) begin
         if (r % 5 == 0) do_reset();
         else do_clear();
         repeat ($urandom_range(5, 2)) random_cfg();
         gap = $urandom_range(2, 0);
         repeat ($urandom_range(3, 0)) random_piece(gap);
         if ($urandom_range(9, 0) != 0) begin
            send_str(delim_pool[$urandom_range(3, 0)], gap);
            send_str("DLAB_TAG", gap);
         end
         repeat (60) random_piece(gap);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      string s;
      reset_n = 1'b0; clear = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      cfg_we = 1'b0; cfg_idx = 3'd0; cfg_word = '0; cfg_len = 4'd0;
      p_c0 = '0; p_c1 = '0;

      // Reset state
      do_reset();
      check("rst_state",  o_state, 0);
      check("rst_counts", o_counts, 0);
      check("rst_bytes",  o_bytes_scanned, 0);
      check("rst_flags",  {o_tag_found, o_end_found, o_done}, 0);

      // Default slot "the", first char case-insensitive, pre/post-tag text ignored
      n_done_pulses = 0;
      send_str("xx the DLAB_TAG\nthe The THE\nDLAB_END the ", 0);
      tick(); tick();
      check("t1_slot0", o_counts[0 +: CNT_W], FOLD_ALL ? 3 : 2);
      check("t1_state", o_state, 2);
      check("t1_bytes", o_bytes_scanned, 36);
      check("t1_done_pulses", n_done_pulses, 1);

      // Words before the start tag are not counted
      do_clear();
      send_str(" the the ", 0);
      check("t2_slot0", o_counts[0 +: CNT_W], 0);
      check("t2_state", o_state, 0);
      check("t2_bytes", o_bytes_scanned, 9);

      // Two programmed slots, closing in different cycles
      do_clear();
      cfg_write(0, "a", 1);
      cfg_write(1, "cat", 3);
      n_both = 0;
      send_str("DLAB_TAG\na cat a\tcat\015DLAB_END", 0);
      tick();
      check("t3_slot0", o_counts[0 +: CNT_W], 2);
      check("t3_slot1", o_counts[CNT_W +: CNT_W], 2);
      check("t3_apart", n_both, 0);

      // Counter saturation
      do_reset();
      s = "DLAB_TAG";
      for (int k = 0; k < 300; k++) s = {s, " the"};
      s = {s, " DLAB_END"};
      send_str(s, 0);
      check("t4_sat", o_counts[0 +: CNT_W], 255);

      // Clear mid-COUNT drops the byte and keeps the configuration
      do_clear();
      send_str("DLAB_TAG\nthe the", 0);
      check("t5_before", o_counts[0 +: CNT_W], 1);
      clear = 1'b1; byte_valid = 1'b1; byte_data = 8'h20;
      tick();
      clear = 1'b0; byte_valid = 1'b0;
      check("t5_state", o_state, 0);
      check("t5_counts", o_counts, 0);
      check("t5_bytes", o_bytes_scanned, 0);
      send_str("DLAB_TAG the ", 0);
      check("t5_cfg_kept", o_counts[0 +: CNT_W], 1);

      // Config write in COUNT is ignored; byte gaps do not change the result
      cfg_write(1, "he", 2);
      send_str(" he the he the ", 3);
      check("t6_slot0", o_counts[0 +: CNT_W], 3);
      check("t6_slot1", o_counts[CNT_W +: CNT_W], 0);
      send_str("DLAB_END", 2);
      tick();
      check("t6_state", o_state, 2);

      // Clamped length: len 15 behaves as MAX_LEN
      do_clear();
      cfg_write(3, "elephant", 15);
      send_str("DLAB_TAG elephant elephants Elephant ", 1);
      check("t7_clamp", o_counts[3*CNT_W +: CNT_W], 2);

      random_rounds();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
